inert_spi_slv: RTL

Synthesizable SPI responder that models the inertial sensor on the far end of the Segway's inertial interface. It decodes 16-bit mode-0 SPI frames from the inertial master, holds a small configuration register file, and serves pitch-rate and Z-acceleration bytes. It raises INT when a new sample is available. The block is used as the sensor stand-in for FPGA bring-up and for closed-loop simulation of the balance path.

---
 rtl/inert_spi_slv_if.sv | 22 ++
 rtl/inert_spi_slv.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/inert_spi_slv_if.sv
// Bus between the inertial SPI master and the sensor stand-in.
// Carries the SPI wires, the INT line and the sample feed.
interface inert_spi_slv_if;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        INT;
    logic        smpl_vld;
    logic [15:0] ptch_rt_in;
    logic [15:0] AZ_in;

    modport master (
        output SS_n, SCLK, MOSI, smpl_vld, ptch_rt_in, AZ_in,
        input  MISO, INT
    );

    modport slave (
        input  SS_n, SCLK, MOSI, smpl_vld, ptch_rt_in, AZ_in,
        output MISO, INT
    );
endinterface

// File: rtl/inert_spi_slv.sv
// Mode-0 16-bit SPI responder modelling the inertial sensor: config regs, pitch/AZ data, INT.
// SAMPLE_LOCK_EN: data regs freeze between committed reads of 0x22 and 0x2D.
module inert_spi_slv (
    input  logic           clk,
    input  logic           rst_n,
    inert_spi_slv_if.slave spi
);

    localparam logic [7:0] WHO_AM_I_VAL = 8'h6A;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [2:0]  r_ss_sync;
    logic [2:0]  r_sclk_sync;
    logic [1:0]  r_mosi_sync;
    logic [1:0]  r_state;
    logic [4:0]  r_bit_cnt;
    logic [15:0] r_shift;
    logic [7:0]  r_tx;
    logic        r_tx_act;
    logic        r_miso;
    logic [7:0]  r_int1_ctrl;
    logic [7:0]  r_ctrl1_xl;
    logic [7:0]  r_ctrl2_g;
    logic [7:0]  r_ctrl5;
    logic [15:0] r_ptch;
    logic [15:0] r_az;
    logic [15:0] r_pend_ptch;
    logic [15:0] r_pend_az;
    logic        r_pend;
    logic        r_cap_d;
    logic        r_clr_d;
    logic        r_int;

    logic        w_ss_fall;
    logic        w_ss_rise;
    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_shift_en;
    logic        w_frame_end;
    logic        w_commit;
    logic        w_frm_rd;
    logic [6:0]  w_frm_addr;
    logic        w_rd2d;
    logic        w_lock;
    logic        w_hold;
    logic        w_cap;
    logic [15:0] w_cap_ptch;
    logic [15:0] w_cap_az;
    logic [7:0]  w_rd_byte;

    // SS_n sync resets low so a select already held low at reset release is not seen as a fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_sync   <= 3'b000;
            r_sclk_sync <= 3'b000;
            r_mosi_sync <= 2'b00;
        end else begin
            r_ss_sync   <= {r_ss_sync[1:0], spi.SS_n};
            r_sclk_sync <= {r_sclk_sync[1:0], spi.SCLK};
            r_mosi_sync <= {r_mosi_sync[0], spi.MOSI};
        end
    end

    assign w_ss_fall   =  r_ss_sync[2]   & ~r_ss_sync[1];
    assign w_ss_rise   = ~r_ss_sync[2]   &  r_ss_sync[1];
    assign w_sclk_rise = ~r_sclk_sync[2] &  r_sclk_sync[1];
    assign w_sclk_fall =  r_sclk_sync[2] & ~r_sclk_sync[1];

    assign w_shift_en  = w_sclk_rise & (r_state != S_IDLE);
    assign w_frame_end = w_ss_rise & (r_state != S_IDLE);
    assign w_commit    = w_frame_end & (r_bit_cnt == 5'd16);
    assign w_frm_rd    = r_shift[15];
    assign w_frm_addr  = r_shift[14:8];
    assign w_rd2d      = w_commit & w_frm_rd & (w_frm_addr == 7'h2D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 5'd0;
            r_shift   <= 16'h0000;
        end else begin
            if (w_shift_en)
                r_shift <= {r_shift[14:0], r_mosi_sync[1]};
            if (w_shift_en && r_bit_cnt != 5'd31)
                r_bit_cnt <= r_bit_cnt + 5'd1;
            case (r_state)
                S_IDLE: if (w_ss_fall) begin
                    r_state   <= S_CMD;
                    r_bit_cnt <= 5'd0;
                end
                S_CMD: begin
                    if (w_ss_rise)
                        r_state <= S_IDLE;
                    else if (w_sclk_rise && r_bit_cnt == 5'd7)
                        r_state <= S_DATA;
                end
                S_DATA: if (w_ss_rise) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Address decode works on the command byte while it still sits in the low half of r_shift
    always_comb begin
        w_rd_byte = 8'h00;
        case (r_shift[6:0])
            7'h0D:   w_rd_byte = r_int1_ctrl;
            7'h0F:   w_rd_byte = WHO_AM_I_VAL;
            7'h10:   w_rd_byte = r_ctrl1_xl;
            7'h11:   w_rd_byte = r_ctrl2_g;
            7'h14:   w_rd_byte = r_ctrl5;
            7'h22:   w_rd_byte = r_ptch[7:0];
            7'h23:   w_rd_byte = r_ptch[15:8];
            7'h2C:   w_rd_byte = r_az[7:0];
            7'h2D:   w_rd_byte = r_az[15:8];
            default: w_rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx     <= 8'h00;
            r_tx_act <= 1'b0;
            r_miso   <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_frame_end) begin
                r_tx     <= 8'h00;
                r_tx_act <= 1'b0;
            end else if (w_sclk_fall && r_state == S_DATA) begin
                if (!r_tx_act && r_bit_cnt == 5'd8) begin
                    r_tx_act <= r_shift[7];
                    r_tx     <= w_rd_byte;
                end else begin
                    r_tx <= {r_tx[6:0], 1'b0};
                end
            end
            r_miso <= r_tx_act & r_tx[7];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int1_ctrl <= 8'h00;
            r_ctrl1_xl  <= 8'h00;
            r_ctrl2_g   <= 8'h00;
            r_ctrl5     <= 8'h00;
        end else if (w_commit && !w_frm_rd) begin
            case (w_frm_addr)
                7'h0D:   r_int1_ctrl <= r_shift[7:0];
                7'h10:   r_ctrl1_xl  <= r_shift[7:0];
                7'h11:   r_ctrl2_g   <= r_shift[7:0];
                7'h14:   r_ctrl5     <= r_shift[7:0];
                default: ;
            endcase
        end
    end

`ifdef SAMPLE_LOCK_EN
    logic r_lock;
    logic w_rd22;

    assign w_rd22 = w_commit & w_frm_rd & (w_frm_addr == 7'h22);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_lock <= 1'b0;
        else if (w_rd2d)
            r_lock <= 1'b0;
        else if (w_rd22)
            r_lock <= 1'b1;
    end

    assign w_lock = r_lock;
`else
    assign w_lock = 1'b0;
`endif

    // While held, strobes park in the pending slot; a newer strobe always wins
    assign w_hold     = (r_state != S_IDLE) | ~r_ss_sync[1] | w_lock;
    assign w_cap      = ~w_hold & (spi.smpl_vld | r_pend);
    assign w_cap_ptch = spi.smpl_vld ? spi.ptch_rt_in : r_pend_ptch;
    assign w_cap_az   = spi.smpl_vld ? spi.AZ_in      : r_pend_az;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptch      <= 16'h0000;
            r_az        <= 16'h0000;
            r_pend_ptch <= 16'h0000;
            r_pend_az   <= 16'h0000;
            r_pend      <= 1'b0;
            r_cap_d     <= 1'b0;
            r_clr_d     <= 1'b0;
        end else begin
            if (w_cap) begin
                r_ptch <= w_cap_ptch;
                r_az   <= w_cap_az;
            end
            if (spi.smpl_vld && w_hold) begin
                r_pend      <= 1'b1;
                r_pend_ptch <= spi.ptch_rt_in;
                r_pend_az   <= spi.AZ_in;
            end else if (w_cap) begin
                r_pend <= 1'b0;
            end
            r_cap_d <= w_cap;
            r_clr_d <= w_rd2d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_int <= 1'b0;
        else if (!r_int1_ctrl[1])
            r_int <= 1'b0;
        else if (r_cap_d)
            r_int <= 1'b1;
        else if (r_clr_d)
            r_int <= 1'b0;
    end

    assign spi.MISO = r_miso;
    assign spi.INT  = r_int;

endmodule
